// File: rtl/gerador_de_padroes.sv
// Serial pattern generator: shifts a LARGURA-bit pattern out MSB-first on x, repeated
// a programmable number of times with an optional idle gap. Define GERADOR_PARIDADE_EN
// to append an even-parity bit after every repetition.
module gerador_de_padroes #(
  parameter int LARGURA = 4,
  parameter int CONT_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LARGURA-1:0] padrao,
  input  logic [CONT_W-1:0]  repeticoes,
  input  logic [CONT_W-1:0]  intervalo,
  input  logic               abortar,
  output logic               x,
  output logic               valido,
  output logic               ocupado,
  output logic               fim
);

  localparam int IW = $clog2(LARGURA);
  localparam logic [IW-1:0] POS_MSB = IW'(LARGURA - 1);

  typedef enum logic [1:0] {OCIOSO, ENVIO, PAUSA, FIM} estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   padrao_q, padrao_d;
  logic [CONT_W-1:0]    rep_q, rep_d;
  logic [CONT_W-1:0]    gap_q, gap_d;
  logic [CONT_W-1:0]    cont_q, cont_d;
  logic [IW-1:0]        pos_q, pos_d;
  logic                 x_q, x_d;
  logic                 valido_q, valido_d;
  logic                 ocupado_q, ocupado_d;
  logic                 fim_q, fim_d;
  logic                 ultimo;

`ifdef GERADOR_PARIDADE_EN
  logic par_q, par_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    estado_d  = estado_q;
    padrao_d  = padrao_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    cont_d    = cont_q;
    pos_d     = pos_q;
    x_d       = 1'b0;
    valido_d  = 1'b0;
    ocupado_d = 1'b0;
    fim_d     = 1'b0;
`ifdef GERADOR_PARIDADE_EN
    par_d  = 1'b0;
    ultimo = par_q;
`else
    ultimo = (pos_q == '0);
`endif

    case (estado_q)
      OCIOSO: begin
        if (start && !abortar) begin
          padrao_d = padrao;
          rep_d    = repeticoes;
          gap_d    = intervalo;
          if (repeticoes != '0) begin
            estado_d  = ENVIO;
            pos_d     = POS_MSB;
            x_d       = padrao[LARGURA-1];
            valido_d  = 1'b1;
            ocupado_d = 1'b1;
          end else begin
            estado_d = FIM;
            fim_d    = 1'b1;
          end
        end
      end

      ENVIO: begin
        if (abortar) begin
          estado_d = OCIOSO;
        end else if (!ultimo) begin
          valido_d  = 1'b1;
          ocupado_d = 1'b1;
`ifdef GERADOR_PARIDADE_EN
          if (pos_q == '0) begin
            par_d = 1'b1;
            x_d   = ^padrao_q;
          end else begin
            pos_d = pos_q - IW'(1);
            x_d   = padrao_q[pos_q - IW'(1)];
          end
`else
          pos_d = pos_q - IW'(1);
          x_d   = padrao_q[pos_q - IW'(1)];
`endif
        end else begin
          rep_d = rep_q - CONT_W'(1);
          if (rep_q == CONT_W'(1)) begin
            estado_d = FIM;
            fim_d    = 1'b1;
          end else if (gap_q == '0) begin
            pos_d     = POS_MSB;
            x_d       = padrao_q[LARGURA-1];
            valido_d  = 1'b1;
            ocupado_d = 1'b1;
          end else begin
            estado_d  = PAUSA;
            cont_d    = gap_q;
            ocupado_d = 1'b1;
          end
        end
      end

      PAUSA: begin
        if (abortar) begin
          estado_d = OCIOSO;
        end else if (cont_q == CONT_W'(1)) begin
          // gap counter was loaded with intervalo, so this is the last idle cycle
          estado_d  = ENVIO;
          cont_d    = '0;
          pos_d     = POS_MSB;
          x_d       = padrao_q[LARGURA-1];
          valido_d  = 1'b1;
          ocupado_d = 1'b1;
        end else begin
          cont_d    = cont_q - CONT_W'(1);
          ocupado_d = 1'b1;
        end
      end

      FIM: estado_d = OCIOSO;

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      estado_q  <= OCIOSO;
      padrao_q  <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      cont_q    <= '0;
      pos_q     <= '0;
      x_q       <= 1'b0;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      padrao_q  <= padrao_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      cont_q    <= cont_d;
      pos_q     <= pos_d;
      x_q       <= x_d;
      valido_q  <= valido_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  assign x       = x_q;
  assign valido  = valido_q;
  assign ocupado = ocupado_q;
  assign fim     = fim_q;

endmodule
